pipeline_hazard_ctrl: RTL and testbench

//  Parametrised successor to the fixed 5-stage stall/flush controller. Arbitrates per-stage

---
 rtl/pipeline_hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush arbiter for an N-stage in-order pipeline. It produces registered per-stage
// stall, flush and bubble strobes and tracks stall statistics.
module hazard_stage_cell #(
  parameter int SW  = 3,
  parameter int IDX = 0
) (
  input  logic [SW-1:0] src,
  input  logic [SW-1:0] k,
  input  logic          k_vld,
  output logic          stall_bit,
  output logic          flush_bit,
  output logic          bubble_bit
);
  localparam logic [SW:0] ID = (SW+1)'(IDX);

  always_comb begin
    flush_bit  = ID < {1'b0, src};
    stall_bit  = k_vld && (ID <= {1'b0, k}) && !flush_bit;
    bubble_bit = k_vld && (ID == ({1'b0, k} + 1'b1));
  end
endmodule

module pipeline_hazard_ctrl #(
  parameter int NSTAGES      = 5,
  parameter int SW           = 3,
  parameter int FLUSH_CYCLES = 1,
  parameter int STALL_TO     = 255,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NSTAGES-1:0] stall_req,
  input  logic               redirect_valid,
  input  logic [SW-1:0]      redirect_src,
  input  logic               timeout_clr,
  output logic [NSTAGES-1:0] stall,
  output logic [NSTAGES-1:0] flush,
  output logic [NSTAGES-1:0] bubble,
  output logic [1:0]         ctrl_state,
  output logic               stall_timeout,
  output logic [CNT_W-1:0]   stall_count
);
  typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, FLUSH = 2'b10} state_t;

  localparam logic [SW-1:0]    LAST  = SW'(NSTAGES-1);
  localparam logic [3:0]       FC    = 4'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] TO    = CNT_W'(STALL_TO);
  localparam logic [CNT_W-1:0] TO_M1 = CNT_W'(STALL_TO-1);

  state_t             state, state_nxt;
  logic [SW-1:0]      src_q, src_nxt, eff_src, k;
  logic [3:0]         fcnt_q, fcnt_nxt;
  logic               rd_ok, accept, hold, k_vld, any_stall;
  logic [NSTAGES-1:0] eff_req, stall_nxt, flush_nxt, bubble_nxt;
  logic [CNT_W-1:0]   wd_q;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      src_q  <= '0;
      fcnt_q <= '0;
    end else begin
      state  <= state_nxt;
      src_q  <= src_nxt;
      fcnt_q <= fcnt_nxt;
    end
  end

  // next-state logic; eff_src is the flush boundary that applies in the next cycle
  always_comb begin
    rd_ok   = redirect_valid && (redirect_src != '0) && (redirect_src <= LAST);
    accept  = rd_ok && ((state != FLUSH) || (redirect_src > src_q));
    hold    = !accept && (state == FLUSH) && (fcnt_q > 4'd1);
    eff_src = accept ? redirect_src : (hold ? src_q : '0);
    for (int i = 0; i < NSTAGES; i++)
      eff_req[i] = stall_req[i] && (SW'(i) >= eff_src);
    k     = '0;
    k_vld = 1'b0;
    for (int i = 0; i < NSTAGES; i++)
      if (eff_req[i]) begin
        k     = SW'(i);
        k_vld = 1'b1;
      end
    src_nxt   = eff_src;
    fcnt_nxt  = '0;
    state_nxt = k_vld ? STALL : RUN;
    if (accept) begin
      fcnt_nxt  = FC;
      state_nxt = FLUSH;
    end else if (hold) begin
      fcnt_nxt  = fcnt_q - 4'd1;
      state_nxt = FLUSH;
    end
  end

  for (genvar g = 0; g < NSTAGES; g++) begin : g_stage
    hazard_stage_cell #(.SW(SW), .IDX(g)) u_cell (
      .src       (eff_src),
      .k         (k),
      .k_vld     (k_vld),
      .stall_bit (stall_nxt[g]),
      .flush_bit (flush_nxt[g]),
      .bubble_bit(bubble_nxt[g])
    );
  end

  // output logic
  always_comb begin
    ctrl_state = state;
    any_stall  = |stall;
  end

  // stall statistics follow the registered stall strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall         <= '0;
      flush         <= '0;
      bubble        <= '0;
      wd_q          <= '0;
      stall_timeout <= 1'b0;
      stall_count   <= '0;
    end else begin
      stall  <= stall_nxt;
      flush  <= flush_nxt;
      bubble <= bubble_nxt;
      if (!any_stall)     wd_q <= '0;
      else if (wd_q != TO) wd_q <= wd_q + 1'b1;
      stall_timeout <= (any_stall && (wd_q == TO_M1)) || (stall_timeout && !timeout_clr);
      if (any_stall && (stall_count != '1)) stall_count <= stall_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: vector table, directed corner sequences and random
// traffic compared against a behavioural model.
module tb_pipeline_hazard_ctrl;
  localparam int N = 5, SW = 3, FC = 3, TO = 4, CW = 4;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0]  stall_req = '0;
  logic          redirect_valid = 1'b0;
  logic [SW-1:0] redirect_src = '0;
  logic          timeout_clr = 1'b0;
  logic [N-1:0]  stall, flush, bubble;
  logic [1:0]    ctrl_state;
  logic          stall_timeout;
  logic [CW-1:0] stall_count;

  pipeline_hazard_ctrl #(.NSTAGES(N), .SW(SW), .FLUSH_CYCLES(FC), .STALL_TO(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .stall_req(stall_req), .redirect_valid(redirect_valid),
    .redirect_src(redirect_src), .timeout_clr(timeout_clr), .stall(stall), .flush(flush),
    .bubble(bubble), .ctrl_state(ctrl_state), .stall_timeout(stall_timeout),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int m_state, m_src, m_left, m_stall, m_flush, m_bubble, m_wd, m_to, m_cnt;

  typedef struct {
    logic [N-1:0]  s;
    logic          rv;
    logic [SW-1:0] src;
    logic [N-1:0]  es, ef, eb;
    logic [1:0]    est;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_src = 0; m_left = 0; m_stall = 0; m_flush = 0;
    m_bubble = 0; m_wd = 0; m_to = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    int src, n_src, n_left, req, k;
    bit valid, any;
    src   = int'(redirect_src);
    valid = redirect_valid && src >= 1 && src <= N-1;
    if (valid && (m_left == 0 || src > m_src)) begin n_src = src; n_left = FC; end
    else if (m_left > 1) begin n_src = m_src; n_left = m_left - 1; end
    else begin n_src = 0; n_left = 0; end
    req = int'(stall_req) & ~((1 << n_src) - 1);
    k = -1;
    for (int i = N-1; i >= 0; i--) if (k < 0 && req[i]) k = i;
    any = (m_stall != 0);
    m_to  = int'((any && m_wd + 1 == TO) || (m_to != 0 && !timeout_clr));
    m_wd  = any ? ((m_wd + 1 > TO) ? TO : m_wd + 1) : 0;
    if (any && m_cnt < (1 << CW) - 1) m_cnt++;
    m_flush  = (1 << n_src) - 1;
    m_stall  = (k >= 0) ? (((1 << (k+1)) - 1) & ~m_flush) : 0;
    m_bubble = (k >= 0 && k+1 < N) ? (1 << (k+1)) : 0;
    m_state  = (n_left > 0) ? 2 : ((k >= 0) ? 1 : 0);
    m_src = n_src; m_left = n_left;
  endtask

  task automatic check_all();
    chk("stall", int'(stall), m_stall);
    chk("flush", int'(flush), m_flush);
    chk("bubble", int'(bubble), m_bubble);
    chk("ctrl_state", int'(ctrl_state), m_state);
    chk("stall_timeout", int'(stall_timeout), m_to);
    chk("stall_count", int'(stall_count), m_cnt);
  endtask

  task automatic cyc(input logic [N-1:0] s, input logic rv, input logic [SW-1:0] src, input logic clr);
    stall_req = s; redirect_valid = rv; redirect_src = src; timeout_clr = clr;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc('0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    stall_req = '0; redirect_valid = 1'b0; redirect_src = '0; timeout_clr = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0] = '{5'b00100, 1'b0, 3'd0, 5'b00111, 5'b00000, 5'b01000, 2'b01};
    tbl[1] = '{5'b10000, 1'b0, 3'd0, 5'b11111, 5'b00000, 5'b00000, 2'b01};
    tbl[2] = '{5'b00001, 1'b0, 3'd0, 5'b00001, 5'b00000, 5'b00010, 2'b01};
    tbl[3] = '{5'b00000, 1'b0, 3'd0, 5'b00000, 5'b00000, 5'b00000, 2'b00};
    tbl[4] = '{5'b00000, 1'b1, 3'd2, 5'b00000, 5'b00011, 5'b00000, 2'b10};
    tbl[5] = '{5'b00000, 1'b1, 3'd0, 5'b00000, 5'b00000, 5'b00000, 2'b00};
    tbl[6] = '{5'b00000, 1'b1, 3'd5, 5'b00000, 5'b00000, 5'b00000, 2'b00};
    tbl[7] = '{5'b00011, 1'b1, 3'd4, 5'b00000, 5'b01111, 5'b00000, 2'b10};
    tbl[8] = '{5'b00110, 1'b1, 3'd1, 5'b00110, 5'b00001, 5'b01000, 2'b10};
    tbl[9] = '{5'b01010, 1'b0, 3'd3, 5'b01111, 5'b00000, 5'b10000, 2'b01};

    model_reset();
    @(posedge clk); #1;
    do_reset();

    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].s, tbl[i].rv, tbl[i].src, 1'b0);
      chk($sformatf("tbl%0d_stall", i), int'(stall), int'(tbl[i].es));
      chk($sformatf("tbl%0d_flush", i), int'(flush), int'(tbl[i].ef));
      chk($sformatf("tbl%0d_bubble", i), int'(bubble), int'(tbl[i].eb));
      chk($sformatf("tbl%0d_state", i), int'(ctrl_state), int'(tbl[i].est));
      idle(4);
    end

    // single-cycle stall bumps stall_count by one
    do_reset();
    cyc(5'b00100, 1'b0, '0, 1'b0);
    chk("t2_stall", int'(stall), 5'b00111);
    idle(1);
    chk("t2_release", int'(ctrl_state), 0);
    chk("t2_count", int'(stall_count), 1);

    // flush window of FC cycles, then exit into STALL when a request is pending
    cyc('0, 1'b1, 3'd2, 1'b0);
    chk("t3_flush1", int'(flush), 5'b00011);
    idle(2);
    chk("t3_flush3", int'(flush), 5'b00011);
    idle(1);
    chk("t3_end", int'(flush), 0);
    cyc('0, 1'b1, 3'd2, 1'b0);
    idle(2);
    cyc(5'b00100, 1'b0, '0, 1'b0);
    chk("t3_exit_stall", int'(ctrl_state), 1);

    // re-arm with an older source; younger source and masked stall ignored
    do_reset();
    cyc('0, 1'b1, 3'd2, 1'b0);
    cyc('0, 1'b1, 3'd3, 1'b0);
    chk("t4_rearm", int'(flush), 5'b00111);
    idle(2);
    chk("t4_reload", int'(flush), 5'b00111);
    idle(1);
    chk("t4_done", int'(flush), 0);
    cyc('0, 1'b1, 3'd2, 1'b0);
    cyc(5'b00001, 1'b1, 3'd1, 1'b0);
    chk("t4_ignore", int'(flush), 5'b00011);
    chk("t4_nostall", int'(stall), 0);
    idle(1);
    chk("t4_orig_len", int'(flush), 5'b00011);
    idle(1);
    chk("t4_orig_end", int'(flush), 0);

    // watchdog
    do_reset();
    repeat (4) cyc(5'b10000, 1'b0, '0, 1'b0);
    chk("t5_pre", int'(stall_timeout), 0);
    idle(1);
    chk("t5_set", int'(stall_timeout), 1);
    cyc('0, 1'b1, 3'd0, 1'b0);
    chk("t5_sticky", int'(stall_timeout), 1);
    chk("t5_src0", int'(ctrl_state), 0);
    cyc('0, 1'b1, 3'd5, 1'b1);
    chk("t5_clr", int'(stall_timeout), 0);
    chk("t5_src5", int'(flush), 0);

    // stall_count saturation
    do_reset();
    repeat (20) cyc(5'b00001, 1'b0, '0, 1'b0);
    idle(1);
    chk("t6_sat", int'(stall_count), 15);

    // asynchronous reset in the middle of a flush
    cyc('0, 1'b1, 3'd3, 1'b0);
    chk("t1_preflush", int'(flush), 5'b00111);
    rst_n = 1'b0;
    #1;
    chk("t1_flush", int'(flush), 0);
    chk("t1_state", int'(ctrl_state), 0);
    chk("t1_count", int'(stall_count), 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] s;
      s = ($urandom_range(0, 2) == 0) ? '0 : N'($urandom);
      if ($urandom_range(0, 3) == 0) s = 5'b10000;
      cyc(s, $urandom_range(0, 9) < 3, SW'($urandom_range(0, 7)), $urandom_range(0, 9) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
